// File: rtl/ibuf_win_ctrl_if.sv
// Handshake/bus bundle for ibuf_win_ctrl: job control, row-load and window ports.
// Optional WIN_CTRL_PERF_EN adds the perf_stall_cnt / perf_load_cnt counters.
interface ibuf_win_ctrl_if #(
    parameter int unsigned CW = 8,
    parameter int unsigned RW = 8
);
    logic          start;
    logic [CW-1:0] cfg_cols;
    logic [RW-1:0] cfg_rows;
    logic          busy;
    logic          done;
    logic          cfg_err;
    logic          ld_req;
    logic [1:0]    ld_row_sel;
    logic          ld_ack;
    logic [2:0]    mux_ctrl;
    logic          win_valid;
    logic          win_ready;
    logic [CW-1:0] win_col;
    logic [RW-1:0] win_row;
`ifdef WIN_CTRL_PERF_EN
    logic [31:0]   perf_stall_cnt;
    logic [31:0]   perf_load_cnt;
`endif

    modport master (
        input  start, cfg_cols, cfg_rows, ld_ack, win_ready,
        output busy, done, cfg_err, ld_req, ld_row_sel, mux_ctrl,
        output win_valid, win_col, win_row
`ifdef WIN_CTRL_PERF_EN
        , output perf_stall_cnt, perf_load_cnt
`endif
    );

    modport slave (
        output start, cfg_cols, cfg_rows, ld_ack, win_ready,
        input  busy, done, cfg_err, ld_req, ld_row_sel, mux_ctrl,
        input  win_valid, win_col, win_row
`ifdef WIN_CTRL_PERF_EN
        , input perf_stall_cnt, perf_load_cnt
`endif
    );
endinterface

// File: rtl/ibuf_win_ctrl.sv
// Scheduler for the 3x3 input-buffer window bank: row loads, rotation-mux ctrl, window issue.
// Define WIN_CTRL_PERF_EN to add the stall/load-wait performance counters.
module ibuf_win_ctrl #(
    parameter int unsigned CW = 8,
    parameter int unsigned RW = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    ibuf_win_ctrl_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_RUN,
        S_LOAD,
        S_DONE
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cols_q;
    logic [RW-1:0] rows_q;
    logic [1:0]    rp_q;
    logic          cp_q;
    logic [CW-1:0] win_col_q;
    logic [RW-1:0] win_row_q;
    logic [1:0]    sel_q;
    logic          ld_req_q;
    logic          win_valid_q;
    logic          busy_q;
    logic          done_q;
    logic          cfg_err_q;
    logic [2:0]    mux_q;

    logic          hs_d;
    logic          ack_d;
    logic          last_col_d;
    logic          last_row_d;
    logic          cfg_bad_d;
    logic [1:0]    rp_d;

    // Row phase selects which bank row is oldest; column phase ping-pongs per window.
    function automatic logic [2:0] ctrl_code(input logic [1:0] rp, input logic cp);
        logic [2:0] code;
        case ({rp, cp})
            3'b000:  code = 3'b000;
            3'b001:  code = 3'b001;
            3'b011:  code = 3'b010;
            3'b010:  code = 3'b011;
            3'b100:  code = 3'b100;
            3'b101:  code = 3'b101;
            default: code = 3'b000;
        endcase
        return code;
    endfunction

    assign hs_d       = win_valid_q & bus.win_ready;
    assign ack_d      = ld_req_q & bus.ld_ack;
    assign last_col_d = (win_col_q == cols_q - CW'(1));
    assign last_row_d = (win_row_q == rows_q - RW'(3));
    assign cfg_bad_d  = (bus.cfg_rows < RW'(3)) || (bus.cfg_cols == '0);
    assign rp_d       = (rp_q == 2'd2) ? 2'd0 : rp_q + 2'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cols_q      <= '0;
            rows_q      <= '0;
            rp_q        <= '0;
            cp_q        <= 1'b0;
            win_col_q   <= '0;
            win_row_q   <= '0;
            sel_q       <= '0;
            ld_req_q    <= 1'b0;
            win_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            mux_q       <= '0;
        end else begin
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        cols_q    <= bus.cfg_cols;
                        rows_q    <= bus.cfg_rows;
                        rp_q      <= '0;
                        cp_q      <= 1'b0;
                        win_col_q <= '0;
                        win_row_q <= '0;
                        busy_q    <= 1'b1;
                        if (cfg_bad_d) begin
                            done_q    <= 1'b1;
                            cfg_err_q <= 1'b1;
                            state_q   <= S_DONE;
                        end else begin
                            ld_req_q <= 1'b1;
                            sel_q    <= '0;
                            mux_q    <= 3'b000;
                            state_q  <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    if (ack_d) begin
                        if (sel_q == 2'd2) begin
                            ld_req_q    <= 1'b0;
                            win_valid_q <= 1'b1;
                            mux_q       <= ctrl_code(rp_q, cp_q);
                            state_q     <= S_RUN;
                        end else begin
                            sel_q <= sel_q + 2'd1;
                        end
                    end
                end
                S_RUN: begin
                    if (hs_d) begin
                        if (last_col_d) begin
                            win_valid_q <= 1'b0;
                            if (last_row_d) begin
                                done_q  <= 1'b1;
                                state_q <= S_DONE;
                            end else begin
                                win_col_q <= '0;
                                cp_q      <= 1'b0;
                                ld_req_q  <= 1'b1;
                                sel_q     <= rp_q;
                                state_q   <= S_LOAD;
                            end
                        end else begin
                            cp_q      <= ~cp_q;
                            win_col_q <= win_col_q + CW'(1);
                            mux_q     <= ctrl_code(rp_q, ~cp_q);
                        end
                    end
                end
                S_LOAD: begin
                    // The oldest row is overwritten, so the phase advances past it.
                    if (ack_d) begin
                        ld_req_q    <= 1'b0;
                        rp_q        <= rp_d;
                        win_row_q   <= win_row_q + RW'(1);
                        win_valid_q <= 1'b1;
                        mux_q       <= ctrl_code(rp_d, 1'b0);
                        state_q     <= S_RUN;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.cfg_err    = cfg_err_q;
    assign bus.ld_req     = ld_req_q;
    assign bus.ld_row_sel = sel_q;
    assign bus.mux_ctrl   = mux_q;
    assign bus.win_valid  = win_valid_q;
    assign bus.win_col    = win_col_q;
    assign bus.win_row    = win_row_q;

`ifdef WIN_CTRL_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] load_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            load_cnt_q  <= '0;
        end else if (state_q == S_IDLE && bus.start) begin
            stall_cnt_q <= '0;
            load_cnt_q  <= '0;
        end else begin
            if (win_valid_q && !bus.win_ready && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (ld_req_q && !bus.ld_ack && load_cnt_q != '1)
                load_cnt_q <= load_cnt_q + 32'd1;
        end
    end

    assign bus.perf_stall_cnt = stall_cnt_q;
    assign bus.perf_load_cnt  = load_cnt_q;
`endif

endmodule
